rtc_cmd_sched: RTL and testbench
================================

Name: rtc_cmd_sched

Overview:
- Schedules all configuration loads into the rtc timer core.
- Two requesters share the core: the host register interface (host_*) and the clock servo (srv_*).
- Each accepted command becomes exactly one single-cycle load strobe (time_ld, period_ld or adj_ld) with stable operand buses.
- Enforces a minimum spacing between strobes and blocks a new fine adjustment while the previous one is still being applied.

Parameters:
- GAP_CYC, 2: idle cycles forced after every issued strobe (0 = back-to-back issue every other cycle).
- MODULO, 38'd256_000000000: value driven on time_acc_modulo (1e9 ns, 8 fractional bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- host_valid  in  1  host command request
- host_ready  out  1  host command accepted when valid&ready
- host_cmd  in  2  0=TIME, 1=PERIOD, 2=ADJ, 3=reserved
- host_sec  in  48  TIME seconds
- host_ns  in  38  TIME ns[37:8] / frac[7:0]
- host_period  in  40  PERIOD or ADJ value, ns[39:32] / frac[31:0]
- host_adj_cnt  in  32  ADJ duration in cycles
- srv_valid, srv_ready, srv_cmd, srv_sec, srv_ns, srv_period, srv_adj_cnt: same widths/meanings as host_*
- time_ld  out  1  strobe to rtc
- time_reg_sec_in  out  48  to rtc
- time_reg_ns_in  out  38  to rtc
- period_ld  out  1  strobe to rtc
- period_in  out  40  to rtc
- adj_ld  out  1  strobe to rtc
- period_adj  out  40  to rtc
- adj_ld_data  out  32  to rtc
- time_acc_modulo  out  38  constant MODULO
- adj_busy  out  1  fine adjustment in progress
- last_src  out  1  0=host, 1=servo granted last
- cmd_err  out  1  one-cycle pulse on reserved cmd accepted

Behaviour:
- Reset (rst=0 at posedge):
  - All strobes, readys, adj_busy, cmd_err, last_src = 0.
  - All data outputs = 0; adj counter = 0; FSM -> IDLE.
  - time_acc_modulo = MODULO at all times.
- FSM states:
  - IDLE: arbitrate. On accept -> ISSUE.
  - ISSUE: exactly one cycle; the strobe for the latched cmd is high. -> GAP if GAP_CYC>0, else IDLE.
  - GAP: count GAP_CYC cycles -> IDLE.
- Eligibility: a request is eligible when valid and (cmd!=ADJ or !adj_busy).
- ready rules:
  - readys are combinational and asserted only in IDLE, to at most one requester per cycle.
  - An ineligible ADJ request waits with ready=0; it is not dropped.
- Arbitration:
  - Round-robin on eligible requesters; the one not equal to last_src wins a tie.
  - last_src updates on accept.
  - A blocked servo ADJ does not block an eligible host command, and vice versa.
- Accept cycle N:
  - Latch cmd and operand fields of the winner.
  - Strobe is high in cycle N+1.
  - The matching operand outputs update in N+1, together with the strobe, and hold until that cmd type is next issued.
  - Other operand buses are unchanged.
- ADJ issue:
  - The adj counter loads adj_cnt in the strobe cycle; adj_busy = (counter!=0).
  - The counter decrements each cycle after, and adj_busy falls the cycle the counter reaches 0.
  - adj_cnt=0: strobe issued, adj_busy stays 0.
- TIME and PERIOD are issued regardless of adj_busy and do not alter the counter.
- Reserved cmd=3:
  - Accepted normally, produces no strobe.
  - cmd_err pulses in the would-be strobe cycle; GAP still applies.
- Never more than one strobe high in any cycle.
- Reset mid-operation: a pending strobe is lost and the adj counter is cleared.
- Requesters must hold fields stable while valid and not ready.

Decomposition:
- Shared package rtc_pkg:
  - cmd codes CMD_TIME/CMD_PERIOD/CMD_ADJ/CMD_RSVD.
  - Field widths: SEC_W=48, NS_W=38, PER_W=40, ADJ_W=32.
  - MODULO default.
- One natural sub-module: rtc_cmd_arb (two-way round-robin with eligibility masking, outputs grant + last_src).
- FSM, operand registers and adj counter stay in the top.

Test Plan:
- Reset: hold rst=0 3 cycles -> all strobes/data 0, readys 0, time_acc_modulo=256000000000.
- Host PERIOD 40'h08_00000000 at cycle N -> period_ld high only at N+1, period_in=40'h08_00000000 held; host_ready low for GAP_CYC+1 cycles.
- Host ADJ period 40'h02_20800000, cnt=10 -> adj_ld 1 cycle, adj_busy high exactly 10 cycles; servo ADJ during busy waits (srv_ready=0) and issues the cycle after busy+GAP clears.
- Host and servo both valid every cycle with PERIOD -> grants alternate host, servo, host...; never two strobes in one cycle.
- Host TIME sec=10, ns={30'd999999990,8'h00} while adj_busy -> time_ld issued immediately; adj counter unaffected.
- cmd=3 from servo -> cmd_err single pulse, no strobe, outputs unchanged. ADJ cnt=0 -> adj_ld pulse, adj_busy never set.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the rtc command scheduler: command codes, field
// widths, the default accumulator modulo and the request bundle type.
package rtc_pkg;
  localparam int SEC_W = 48;
  localparam int NS_W  = 38;
  localparam int PER_W = 40;
  localparam int ADJ_W = 32;

  // 1e9 ns with 8 fractional bits
  localparam logic [NS_W-1:0] MODULO_DEF = 38'd256_000000000;

  typedef enum logic [1:0] {
    CMD_TIME   = 2'd0,
    CMD_PERIOD = 2'd1,
    CMD_ADJ    = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_e;

  typedef struct packed {
    cmd_e             cmd;
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
    logic [PER_W-1:0] period;
    logic [ADJ_W-1:0] adj_cnt;
  } cmd_req_t;

  // An ADJ request must wait while the previous fine adjustment runs.
  function automatic logic is_elig(input logic valid, input cmd_e cmd, input logic busy);
    return valid && ((cmd != CMD_ADJ) || !busy);
  endfunction
endpackage

// File: rtl/rtc_cmd_sched_if.sv
// One requester's command channel into the scheduler (valid/ready + operands).
interface rtc_cmd_sched_if import rtc_pkg::*; ();
  logic             valid;
  logic             ready;
  logic [1:0]       cmd;
  logic [SEC_W-1:0] sec;
  logic [NS_W-1:0]  ns;
  logic [PER_W-1:0] period;
  logic [ADJ_W-1:0] adj_cnt;

  modport master (output valid, cmd, sec, ns, period, adj_cnt, input ready);
  modport slave  (input valid, cmd, sec, ns, period, adj_cnt, output ready);
endinterface

// File: rtl/rtc_cmd_arb.sv
// Two-way round-robin arbiter over pre-masked eligible requests.
// Bit 0 = host, bit 1 = servo.
module rtc_cmd_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] elig,
  output logic [1:0] grant,
  output logic       last_src
);
  // a lone eligible requester wins; on a tie the one not granted last wins
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (elig == 2'b11) grant = last_src ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  // remember who was granted so the next tie goes the other way
  always_ff @(posedge clk) begin
    if (!rst)        last_src <= 1'b0;
    else if (|grant) last_src <= grant[1];
  end
endmodule

// File: rtl/rtc_cmd_sched.sv
// Serialises host and servo configuration loads into the rtc timer core:
// one single-cycle strobe per accepted command, forced idle gap afterwards,
// and ADJ held off while a previous fine adjustment is still running.
module rtc_cmd_sched import rtc_pkg::*; #(
  parameter int              GAP_CYC = 2,
  parameter logic [NS_W-1:0] MODULO  = MODULO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rtc_cmd_sched_if.slave   host,
  rtc_cmd_sched_if.slave   srv,
  output logic             time_ld,
  output logic [SEC_W-1:0] time_reg_sec_in,
  output logic [NS_W-1:0]  time_reg_ns_in,
  output logic             period_ld,
  output logic [PER_W-1:0] period_in,
  output logic             adj_ld,
  output logic [PER_W-1:0] period_adj,
  output logic [ADJ_W-1:0] adj_ld_data,
  output logic [NS_W-1:0]  time_acc_modulo,
  output logic             adj_busy,
  output logic             last_src,
  output logic             cmd_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e           state;
  logic [GW-1:0]    gap_cnt;
  logic [ADJ_W-1:0] adj_cnt;
  logic [1:0]       elig, grant;
  cmd_req_t         h_req, s_req, win;

  assign h_req = '{cmd: cmd_e'(host.cmd), sec: host.sec, ns: host.ns,
                   period: host.period, adj_cnt: host.adj_cnt};
  assign s_req = '{cmd: cmd_e'(srv.cmd), sec: srv.sec, ns: srv.ns,
                   period: srv.period, adj_cnt: srv.adj_cnt};

  assign adj_busy = (adj_cnt != '0);
  assign elig     = {is_elig(srv.valid, s_req.cmd, adj_busy),
                     is_elig(host.valid, h_req.cmd, adj_busy)};
  assign win      = grant[1] ? s_req : h_req;

  assign host.ready      = grant[0];
  assign srv.ready       = grant[1];
  assign time_acc_modulo = MODULO;

  // readys only in IDLE and never while reset is asserted
  rtc_cmd_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == IDLE) && rst),
    .elig     (elig),
    .grant    (grant),
    .last_src (last_src)
  );

  // Scheduler FSM. Strobes and operands are registered on the accept edge,
  // so they are visible exactly during the ISSUE cycle; the adj counter
  // loads on the same edge and counts down afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      adj_cnt         <= '0;
      time_ld         <= 1'b0;
      period_ld       <= 1'b0;
      adj_ld          <= 1'b0;
      cmd_err         <= 1'b0;
      time_reg_sec_in <= '0;
      time_reg_ns_in  <= '0;
      period_in       <= '0;
      period_adj      <= '0;
      adj_ld_data     <= '0;
    end else begin
      time_ld   <= 1'b0;
      period_ld <= 1'b0;
      adj_ld    <= 1'b0;
      cmd_err   <= 1'b0;
      if (adj_busy) adj_cnt <= adj_cnt - 1'b1;
      case (state)
        IDLE: if (|grant) begin
          state <= ISSUE;
          case (win.cmd)
            CMD_TIME: begin
              time_ld         <= 1'b1;
              time_reg_sec_in <= win.sec;
              time_reg_ns_in  <= win.ns;
            end
            CMD_PERIOD: begin
              period_ld <= 1'b1;
              period_in <= win.period;
            end
            CMD_ADJ: begin
              // only accepted with the counter already at zero
              adj_ld      <= 1'b1;
              period_adj  <= win.period;
              adj_ld_data <= win.adj_cnt;
              adj_cnt     <= win.adj_cnt;
            end
            default: cmd_err <= 1'b1;
          endcase
        end
        ISSUE: begin
          if (GAP_CYC > 0) begin
            state   <= GAP;
            gap_cnt <= GW'(GAP_CYC - 1);
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rtc_cmd_sched.sv
// Bench for rtc_cmd_sched: directed scenarios then random traffic, every
// cycle checked against a timeline model (accept cycle -> strobe cycle,
// busy window, next free cycle, tie-break owner).
module tb_rtc_cmd_sched;
  import rtc_pkg::*;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rtc_cmd_sched_if h ();
  rtc_cmd_sched_if s ();

  logic             time_ld, period_ld, adj_ld, adj_busy, last_src, cmd_err;
  logic [SEC_W-1:0] time_reg_sec_in;
  logic [NS_W-1:0]  time_reg_ns_in, time_acc_modulo;
  logic [PER_W-1:0] period_in, period_adj;
  logic [ADJ_W-1:0] adj_ld_data;

  rtc_cmd_sched #(.GAP_CYC(GAP)) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (h),
    .srv             (s),
    .time_ld         (time_ld),
    .time_reg_sec_in (time_reg_sec_in),
    .time_reg_ns_in  (time_reg_ns_in),
    .period_ld       (period_ld),
    .period_in       (period_in),
    .adj_ld          (adj_ld),
    .period_adj      (period_adj),
    .adj_ld_data     (adj_ld_data),
    .time_acc_modulo (time_acc_modulo),
    .adj_busy        (adj_busy),
    .last_src        (last_src),
    .cmd_err         (cmd_err)
  );

  int checks = 0;
  int errors = 0;

  // model state
  longint           t       = 0;   // cycle index (posedge count since start)
  longint           free_at = 0;   // first cycle a new accept may happen
  longint           adj_end = -1;  // last cycle adj_busy is high
  bit               last_m  = 1'b0;
  int               pend    = -1;  // cmd whose strobe is expected this cycle
  logic [SEC_W-1:0] e_sec   = '0;
  logic [NS_W-1:0]  e_ns    = '0;
  logic [PER_W-1:0] e_per   = '0, e_adjp = '0;
  logic [ADJ_W-1:0] e_adjd  = '0;
  bit               acc_h, acc_s;
  longint           tacc_h, tacc_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // One cycle: caller drives inputs at the negedge, then calls step.
  task automatic step();
    bit bsy, idle, eh, es;
    int win;
    #1;
    chk("time_ld",   time_ld,   pend == 0);
    chk("period_ld", period_ld, pend == 1);
    chk("adj_ld",    adj_ld,    pend == 2);
    chk("cmd_err",   cmd_err,   pend == 3);
    chk("one_strobe", ($countones({time_ld, period_ld, adj_ld}) <= 1), 1);
    chk("adj_busy",  adj_busy,  t <= adj_end);
    chk("last_src",  last_src,  last_m);
    chk("time_sec",  time_reg_sec_in, e_sec);
    chk("time_ns",   time_reg_ns_in,  e_ns);
    chk("period_in", period_in,  e_per);
    chk("period_adj", period_adj, e_adjp);
    chk("adj_data",  adj_ld_data, e_adjd);
    chk("modulo",    time_acc_modulo, 38'd256000000000);

    idle = (t >= free_at);
    bsy  = (t <= adj_end);
    eh   = h.valid && (h.cmd != 2'd2 || !bsy);
    es   = s.valid && (s.cmd != 2'd2 || !bsy);
    win  = 0;
    if (idle) begin
      if (eh && es) win = last_m ? 1 : 2;
      else if (eh)  win = 1;
      else if (es)  win = 2;
    end
    chk("host_ready", h.ready, win == 1);
    chk("srv_ready",  s.ready, win == 2);

    acc_h = (win == 1);
    acc_s = (win == 2);
    pend  = -1;
    if (win != 0) begin
      logic [1:0]       c;
      logic [SEC_W-1:0] sc;
      logic [NS_W-1:0]  n;
      logic [PER_W-1:0] p;
      logic [ADJ_W-1:0] k;
      if (win == 1) begin
        c = h.cmd; sc = h.sec; n = h.ns; p = h.period; k = h.adj_cnt; tacc_h = t;
      end else begin
        c = s.cmd; sc = s.sec; n = s.ns; p = s.period; k = s.adj_cnt; tacc_s = t;
      end
      pend    = int'(c);
      free_at = t + GAP + 2;
      last_m  = (win == 2);
      case (c)
        2'd0: begin e_sec = sc; e_ns = n; end
        2'd1: e_per = p;
        2'd2: begin e_adjp = p; e_adjd = k; adj_end = t + longint'(k); end
        default: ;
      endcase
    end
    t++;
    @(negedge clk);
  endtask

  // Reset for n cycles with the host pushing; everything must read zero.
  task automatic do_reset(input int n);
    rst = 1'b0;
    h.valid = 1'b1; h.cmd = 2'd1;
    s.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_host_ready", h.ready, 0);
      chk("rst_srv_ready",  s.ready, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_strobes", {time_ld, period_ld, adj_ld, cmd_err}, 0);
      chk("rst_busy",    adj_busy, 0);
      chk("rst_last",    last_src, 0);
      chk("rst_data",    {time_reg_sec_in, time_reg_ns_in} | 86'(period_in)
                         | 86'(period_adj) | 86'(adj_ld_data), 0);
      chk("rst_modulo",  time_acc_modulo, 38'd256000000000);
      t++;
    end
    rst = 1'b1;
    h.valid = 1'b0;
    pend = -1; free_at = t; adj_end = -1; last_m = 1'b0;
    e_sec = '0; e_ns = '0; e_per = '0; e_adjp = '0; e_adjd = '0;
  endtask

  // Step until every requester that is valid has been accepted.
  task automatic run_all(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      step();
      if (acc_h) h.valid = 1'b0;
      if (acc_s) s.valid = 1'b0;
      done = !h.valid && !s.valid;
    end
    chk("run_timeout", done, 1);
  endtask

  task automatic rnd(output logic [1:0] c, output logic [SEC_W-1:0] sc,
                     output logic [NS_W-1:0] n, output logic [PER_W-1:0] p,
                     output logic [ADJ_W-1:0] k);
    c  = 2'($urandom_range(0, 3));
    sc = {16'($urandom), $urandom};
    n  = {6'($urandom), $urandom};
    p  = {8'($urandom), $urandom};
    k  = $urandom_range(0, 12);
  endtask

  initial begin
    bit     hv, sv, prev_w, have_prev;
    longint a;
    h.valid = 1'b0; h.cmd = '0; h.sec = '0; h.ns = '0; h.period = '0; h.adj_cnt = '0;
    s.valid = 1'b0; s.cmd = '0; s.sec = '0; s.ns = '0; s.period = '0; s.adj_cnt = '0;
    @(negedge clk);

    // reset state
    do_reset(3);

    // host PERIOD, then ADJ queued right behind it (ready low through the gap)
    h.cmd = 2'd1; h.period = 40'h08_00000000; h.valid = 1'b1;
    run_all(10);
    a = tacc_h;
    h.cmd = 2'd2; h.period = 40'h02_20800000; h.adj_cnt = 32'd10; h.valid = 1'b1;
    run_all(20);
    chk("adj_after_gap", tacc_h - a, GAP + 2);

    // servo ADJ waits out the busy window; host TIME goes through meanwhile
    a = tacc_h;
    s.cmd = 2'd2; s.period = 40'h01_00000000; s.adj_cnt = 32'd5; s.valid = 1'b1;
    h.cmd = 2'd0; h.sec = 48'd10; h.ns = {30'd999999990, 8'h00}; h.valid = 1'b1;
    run_all(40);
    chk("time_during_busy", tacc_h, a + GAP + 2);
    chk("srv_adj_cycle",    tacc_s, a + 11);
    run_all(10);

    // both PERIOD every cycle: grants must alternate
    have_prev = 1'b0;
    h.cmd = 2'd1; h.period = {8'($urandom), $urandom}; h.valid = 1'b1;
    s.cmd = 2'd1; s.period = {8'($urandom), $urandom}; s.valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (acc_h || acc_s) begin
        if (have_prev) chk("alternate", acc_s, !prev_w);
        prev_w = acc_s; have_prev = 1'b1;
      end
      if (acc_h) h.period = {8'($urandom), $urandom};
      if (acc_s) s.period = {8'($urandom), $urandom};
    end
    h.valid = 1'b0; s.valid = 1'b0;
    run_all(8);

    // reserved cmd from servo, then ADJ with zero count
    s.cmd = 2'd3; s.period = 40'hFF_FFFFFFFF; s.sec = '1; s.valid = 1'b1;
    run_all(10);
    h.cmd = 2'd2; h.period = 40'h00_12345678; h.adj_cnt = 32'd0; h.valid = 1'b1;
    run_all(10);
    for (int i = 0; i < 4; i++) step();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (!h.valid || acc_h) begin
        hv = ($urandom_range(0, 2) != 0);
        rnd(h.cmd, h.sec, h.ns, h.period, h.adj_cnt);
        h.valid = hv;
      end
      if (!s.valid || acc_s) begin
        sv = ($urandom_range(0, 2) != 0);
        rnd(s.cmd, s.sec, s.ns, s.period, s.adj_cnt);
        s.valid = sv;
      end
      step();
    end
    h.valid = 1'b0; s.valid = 1'b0;
    run_all(20);

    // reset in the middle of a fine adjustment clears the counter
    h.cmd = 2'd2; h.period = 40'h03_00000000; h.adj_cnt = 32'd8; h.valid = 1'b1;
    run_all(30);
    step();
    do_reset(2);
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
